// File: rtl/serial_slice_alu.sv
// Bit-serial (SLICE bits/cycle) ALU with start/done handshake and registered carry chain.
// Optional abort input enabled by defining SERIAL_ALU_ABORT_EN.
module serial_slice_alu #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef SERIAL_ALU_ABORT_EN
   input  logic             abort,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       ALUOp,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carryOut,
   output logic             overflow
);

   localparam int unsigned NumSlice = WIDTH / SLICE;
   localparam int unsigned CntW     = (NumSlice > 1) ? $clog2(NumSlice) : 1;

   if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : gen_bad_cfg
      $error("serial_slice_alu: SLICE must be >= 1 and divide WIDTH");
   end

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  a_q, b_q, acc_q;
   logic [3:0]        op_q;
   logic              carry_q, cmsb_q;
   logic [CntW-1:0]   cnt_q;

   logic              abort_w;
   logic [SLICE-1:0]  a_f, b_f, slice_res;
   logic [SLICE:0]    sum_w;
   logic              cin_msb, is_arith, ovf_w;
   logic [WIDTH-1:0]  fin_res;

`ifdef SERIAL_ALU_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   always_comb begin
      a_f       = op_q[3] ? ~a_q[SLICE-1:0] : a_q[SLICE-1:0];
      b_f       = op_q[2] ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
      sum_w     = {1'b0, a_f} + {1'b0, b_f} + {{SLICE{1'b0}}, carry_q};
      // Carry into the slice MSB recovered from the sum bit and its operands.
      cin_msb   = sum_w[SLICE-1] ^ a_f[SLICE-1] ^ b_f[SLICE-1];
      slice_res = sum_w[SLICE-1:0];
      case (op_q[1:0])
         2'b00:   slice_res = a_f & b_f;
         2'b01:   slice_res = a_f | b_f;
         default: slice_res = sum_w[SLICE-1:0];
      endcase
      is_arith  = op_q[1];
      ovf_w     = is_arith & (cmsb_q ^ carry_q);
      fin_res   = (op_q[1:0] == 2'b11) ? WIDTH'(acc_q[WIDTH-1] ^ ovf_w) : acc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         op_q     <= '0;
         carry_q  <= 1'b0;
         cmsb_q   <= 1'b0;
         cnt_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         zero     <= 1'b1;
         carryOut <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start && !abort_w) begin
                  a_q     <= a;
                  b_q     <= b;
                  op_q    <= ALUOp;
                  carry_q <= ALUOp[2];
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               if (abort_w) begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  // Operands shift down; results enter at the top so slice 0 lands at bit 0.
                  a_q     <= a_q >> SLICE;
                  b_q     <= b_q >> SLICE;
                  acc_q   <= (acc_q >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
                  carry_q <= sum_w[SLICE];
                  cmsb_q  <= cin_msb;
                  cnt_q   <= cnt_q + 1'b1;
                  if (cnt_q == CntW'(NumSlice - 1)) state_q <= StFin;
               end
            end
            StFin: begin
               busy    <= 1'b0;
               state_q <= StIdle;
               if (!abort_w) begin
                  result   <= fin_res;
                  zero     <= (fin_res == '0);
                  carryOut <= is_arith & carry_q;
                  overflow <= ovf_w;
                  done     <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_slice_alu.sv
// Directed self-checking bench for serial_slice_alu (default, SLICE=64 and SLICE=1 instances).
module tb_serial_slice_alu;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        start2 = 1'b0;
   logic        abort = 1'b0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic [3:0]  aluop = '0;

   logic        busy, done, zero, carry_out, ovf;
   logic [63:0] result;
   logic        busy64, done64, zero64, carry64, ovf64;
   logic [63:0] result64;
   logic        busy1, done1, zero1, carry1, ovf1;
   logic [63:0] result1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_slice_alu #(.WIDTH(64), .SLICE(8)) dut (
      .clk(clk), .reset(reset), .start(start),
`ifdef SERIAL_ALU_ABORT_EN
      .abort(abort),
`endif
      .a(a), .b(b), .ALUOp(aluop), .busy(busy), .done(done), .result(result),
      .zero(zero), .carryOut(carry_out), .overflow(ovf)
   );

   serial_slice_alu #(.WIDTH(64), .SLICE(64)) dut_s64 (
      .clk(clk), .reset(reset), .start(start2),
`ifdef SERIAL_ALU_ABORT_EN
      .abort(1'b0),
`endif
      .a(a), .b(b), .ALUOp(aluop), .busy(busy64), .done(done64), .result(result64),
      .zero(zero64), .carryOut(carry64), .overflow(ovf64)
   );

   serial_slice_alu #(.WIDTH(64), .SLICE(1)) dut_s1 (
      .clk(clk), .reset(reset), .start(start2),
`ifdef SERIAL_ALU_ABORT_EN
      .abort(1'b0),
`endif
      .a(a), .b(b), .ALUOp(aluop), .busy(busy1), .done(done1), .result(result1),
      .zero(zero1), .carryOut(carry1), .overflow(ovf1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op; lat counts edges from the start-sampling edge to the edge raising done.
   task automatic run_op(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv,
                         output int lat);
      aluop = op;
      a     = av;
      b     = bv;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      int dcount;
      int l64;
      int l1;

      tick();
      tick();
      reset = 1'b0;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_zero", 64'(zero), 64'd1);
      check("rst_carry", 64'(carry_out), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);

      run_op(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat);
      check("add_wrap_lat", 64'(lat), 64'd10);
      check("add_wrap_done", 64'(done), 64'd1);
      check("add_wrap_res", result, 64'd0);
      check("add_wrap_zero", 64'(zero), 64'd1);
      check("add_wrap_carry", 64'(carry_out), 64'd1);
      check("add_wrap_ovf", 64'(ovf), 64'd0);
      check("add_wrap_busy", 64'(busy), 64'd0);
      tick();
      check("done_one_cycle", 64'(done), 64'd0);

      run_op(4'b0110, 64'd5, 64'd7, lat);
      check("sub_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("sub_carry", 64'(carry_out), 64'd0);
      check("sub_zero", 64'(zero), 64'd0);

      run_op(4'b0111, 64'd5, 64'd7, lat);
      check("slt_res", result, 64'd1);

      run_op(4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat);
      check("ovf_res", result, 64'h8000_0000_0000_0000);
      check("ovf_flag", 64'(ovf), 64'd1);
      check("ovf_carry", 64'(carry_out), 64'd0);

      run_op(4'b1100, 64'd0, 64'd0, lat);
      check("nor_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
      check("nor_carry", 64'(carry_out), 64'd0);
      check("nor_ovf", 64'(ovf), 64'd0);

      // Start pulses during RUN must be ignored.
      aluop  = 4'b0010;
      a      = 64'd10;
      b      = 64'd20;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      dcount = 0;
      for (int i = 1; i <= 14; i++) begin
         start = (i == 2 || i == 5);
         a     = (i == 2 || i == 5) ? 64'd1000 : 64'd10;
         if (i == 5) check("no_partial", result, 64'hFFFF_FFFF_FFFF_FFFF);
         tick();
         if (done) dcount++;
      end
      start = 1'b0;
      check("ign_done_count", 64'(dcount), 64'd1);
      check("ign_res", result, 64'd30);

      // Start held high through done: second op launches back-to-back.
      a     = 64'd1;
      b     = 64'd2;
      start = 1'b1;
      tick();
      check("b2b_busy1", 64'(busy), 64'd1);
      lat = 1;
      while (!done && lat < 200) begin
         tick();
         lat++;
      end
      check("b2b_res1", result, 64'd3);
      a = 64'd100;
      b = 64'd200;
      tick();
      start = 1'b0;
      check("b2b_busy2", 64'(busy), 64'd1);
      lat = 1;
      while (!done && lat < 200) begin
         tick();
         lat++;
      end
      check("b2b_lat2", 64'(lat), 64'd10);
      check("b2b_res2", result, 64'd300);

      // Reset in RUN cycle 3.
      a     = 64'd5;
      b     = 64'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_res", result, 64'd0);
      check("mid_rst_zero", 64'(zero), 64'd1);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) dcount++;
         tick();
      end
      check("mid_rst_no_done", 64'(dcount), 64'd0);

`ifdef SERIAL_ALU_ABORT_EN
      run_op(4'b0010, 64'd4, 64'd5, lat);
      check("pre_abort_res", result, 64'd9);
      a     = 64'd1;
      b     = 64'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_res", result, 64'd9);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) dcount++;
         tick();
      end
      check("abort_no_done", 64'(dcount), 64'd0);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("abort_idle_start", 64'(busy), 64'd0);
`endif

      // SLICE=64 and SLICE=1 builds side by side; start edge counts as edge 1.
      aluop  = 4'b0010;
      a      = 64'd3;
      b      = 64'd4;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      l64    = 0;
      l1     = 0;
      for (int i = 2; i <= 80; i++) begin
         tick();
         if (done64 && l64 == 0) l64 = i;
         if (done1 && l1 == 0) l1 = i;
      end
      check("s64_lat", 64'(l64), 64'd3);
      check("s64_res", result64, 64'd7);
      check("s1_lat", 64'(l1), 64'd66);
      check("s1_res", result1, 64'd7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_slice_alu.md
Name: serial_slice_alu

Overview:
- Multi-cycle, parametrised ALU that processes its operands SLICE bits per clock, LSB slice first.
- A registered carry chains the slices from one cycle to the next.
- Supports the 4-bit ALUOp encoding of the single-bit ALU cell (ainvert, bnegate, op select), plus set-less-than and full flags.
- Sits beside the datapath as the area-reduced execute unit, with a start/done handshake to the control FSM.

Parameters:
- WIDTH, 64: operand and result width in bits.
- SLICE, 8: bits processed per cycle. WIDTH % SLICE must be 0 and SLICE ≥ 1; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepted start.
- b  input  WIDTH  operand B; sampled on the accepted start.
- ALUOp  input  4  [3] ainvert, [2] bnegate, [1:0] select (00 AND, 01 OR, 10 ADD, 11 SLT); sampled on the accepted start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse when result and flags are valid.
- result  output  WIDTH  final result; held until the next accepted start.
- zero  output  1  result == 0.
- carryOut  output  1  carry out of bit WIDTH-1 (add/SLT paths; 0 for AND/OR).
- overflow  output  1  signed overflow of the add path (add/SLT; 0 for AND/OR).

Behaviour:
- Reset:
  - state = IDLE.
  - busy = 0, done = 0, result = 0, zero = 1, carryOut = 0, overflow = 0.
  - Internal slice counter and carry register cleared.
- States: IDLE, RUN, FIN.
- IDLE:
  - start = 1 → latch a, b and ALUOp.
  - carry register ← ALUOp[2], so subtract = invert B plus 1.
  - Slice counter ← 0; busy ← 1; go to RUN.
  - start = 0 → stay in IDLE.
- RUN, each cycle, on slice k (bits [k*SLICE +: SLICE]):
  - aF = ALUOp[3] ? ~a_k : a_k; bF = ALUOp[2] ? ~b_k : b_k.
  - AND/OR write aF&bF or aF|bF into the slice.
  - ADD/SLT: {c, s} = aF + bF + carry; carry ← c; the sum slice is written into the result shift/slot register.
  - Counter increments; on the last slice (k = WIDTH/SLICE-1) go to FIN.
  - RUN always lasts exactly WIDTH/SLICE cycles.
- FIN (one cycle):
  - overflow = carry into MSB XOR carry out of MSB.
  - For SLT, result ← {WIDTH-1 zeros, sum[WIDTH-1] ^ overflow}.
  - zero, carryOut and overflow become valid.
  - busy ← 0, done ← 1 for this cycle only, then go to IDLE.
- Latency:
  - Start accepted at edge N → done high in the cycle after edge N+WIDTH/SLICE+1.
  - Total WIDTH/SLICE+2 edges from start sample to done deassert.
- Outputs:
  - result and flags visibly change only at the FIN edge; no partial result is exposed.
  - They hold through IDLE until the next FIN.
- start while busy, or in FIN, is ignored; no queueing.
- start in the same cycle that done is high is accepted, because FIN has already moved to IDLE at that edge.
- reset mid-operation: abandon the operation; all outputs return to their reset values on that edge; no done pulse.
- SLICE = WIDTH degenerates to a 1-cycle RUN; behaviour is otherwise identical.
- Wrap-around: ADD is modulo 2^WIDTH; carryOut reports the dropped bit.

Optional Feature:
- Macro: SERIAL_ALU_ABORT_EN.
- When defined, adds input port abort (1 bit, after start).
  - abort = 1 in RUN or FIN → next edge goes to IDLE with busy = 0 and done = 0.
  - result and flags keep their previous values.
  - abort in IDLE has no effect; start and abort together in IDLE → start is ignored.
- When undefined, there is no abort port; every accepted start runs to completion.

Test Plan:
- WIDTH=64, SLICE=8; ALUOp=0010, a=0xFFFFFFFFFFFFFFFF, b=1 → after 10 edges done pulses once; result=0, zero=1, carryOut=1, overflow=0.
- ALUOp=0110, a=5, b=7 → result=0xFFFFFFFFFFFFFFFE, carryOut=0, zero=0. Then ALUOp=0111, same operands → result=1.
- ALUOp=0010, a=0x7FFFFFFFFFFFFFFF, b=1 → result=0x8000000000000000, overflow=1. ALUOp=1100 (NOR), a=0, b=0 → result all ones, carryOut=0.
- Pulse start again on RUN cycles 2 and 5 → ignored; only one done pulse; result unchanged from the first operation. start held high through done → a second operation starts back-to-back.
- Assert reset in RUN cycle 3 → next edge: busy=0, result=0, zero=1; no done pulse. With SERIAL_ALU_ABORT_EN, abort in RUN cycle 3 → busy=0, no done, prior result kept.
- SLICE=64 and SLICE=1 builds, ALUOp=0010, a=3, b=4 → result=7. Done at edge 3 and edge 66 respectively.
